// File: rtl/audio_bit_deserializer.sv
// Serial-to-parallel audio packer: MSB-first bit assembly into
// SAMPLE_W-bit words, buffered in a small FIFO with valid/ready output.
module audio_bit_deserializer #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_bit,
  input  logic                in_valid,
  input  logic                align,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W:0]     fill_level,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int BC_W  = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(SAMPLE_W - 1);
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_ONE = (ADDR_W + 1)'(1);

  logic [SAMPLE_W-2:0] sh;
  logic [BC_W-1:0]     bc;
  logic [SAMPLE_W-1:0] word;
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W-1:0]   rd_nxt;
  logic                full;
  logic                pop;
  logic                push_req;
  logic                push;
  logic                drop;

  assign word     = {sh, in_bit};
  assign full     = (fill_level == LVL_FULL);
  assign out_valid = (fill_level != '0);
  assign pop      = out_valid && out_ready;
  assign push_req = in_valid && !align && (bc == BC_LAST);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign rd_nxt   = rd_ptr + 1'b1;

  // Bit assembly: align restarts the word, completion wraps the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
      bc <= '0;
    end else if (align) begin
      sh <= (SAMPLE_W - 1)'(in_bit);
      bc <= in_valid ? BC_W'(1) : '0;
    end else if (in_valid) begin
      sh <= word[SAMPLE_W-2:0];
      bc <= (bc == BC_LAST) ? '0 : bc + 1'b1;
    end
  end

  // FIFO storage; data array needs no reset, occupancy is tracked below.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // Pointers and occupancy; simultaneous push and pop keep the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      unique case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Registered head word: refreshed on pop or on push into an empty FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
    end else if (pop) begin
      if (fill_level > LVL_ONE) out_data <= mem[rd_nxt];
      else if (push)            out_data <= word;
    end else if (push && !out_valid) begin
      out_data <= word;
    end
  end

  // Sticky drop flag; a new drop outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_audio_bit_deserializer.sv
// Directed bench for audio_bit_deserializer.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_audio_bit_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_bit;
  logic       in_valid;
  logic       align;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fill_level;
  logic       overflow;
  logic       clr_ovf;

  int vectors = 0;
  int errors  = 0;

  audio_bit_deserializer #(.SAMPLE_W(8), .ADDR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .align      (align),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feed 8 bits MSB-first; optional idle cycle before each bit;
  // optionally raise out_ready together with the final bit.
  task automatic send_word(input logic [7:0] w,
                           input bit gap,
                           input bit rdy_last);
    for (int i = 7; i >= 0; i--) begin
      if (gap) begin
        in_valid = 1'b0;
        tick();
      end
      if (rdy_last && i == 0) out_ready = 1'b1;
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0;
    align = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_fill", 32'(fill_level), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);

    // Basic pack
    out_ready = 1'b1;
    send_word(8'hA5, 1'b0, 1'b0);
    check("pack_valid", 32'(out_valid), 32'h1);
    check("pack_data", 32'(out_data), 32'hA5);
    check("pack_fill", 32'(fill_level), 32'h1);
    tick();
    check("pack_pop_fill", 32'(fill_level), 32'h0);
    check("pack_pop_valid", 32'(out_valid), 32'h0);

    // Gapped input
    send_word(8'hA5, 1'b1, 1'b0);
    check("gap_data", 32'(out_data), 32'hA5);
    check("gap_fill", 32'(fill_level), 32'h1);
    tick();
    tick();
    check("gap_no_extra", 32'(fill_level), 32'h0);

    // Backpressure and overflow
    out_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    check("bp_fill4", 32'(fill_level), 32'h4);
    check("bp_ovf0", 32'(overflow), 32'h0);
    send_word(8'h55, 1'b0, 1'b0);
    check("bp_fill_full", 32'(fill_level), 32'h4);
    check("bp_ovf1", 32'(overflow), 32'h1);
    check("bp_head", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    check("bp_d0", 32'(out_data), 32'h11); tick();
    check("bp_d1", 32'(out_data), 32'h22); tick();
    check("bp_d2", 32'(out_data), 32'h33); tick();
    check("bp_d3", 32'(out_data), 32'h44); tick();
    check("bp_empty", 32'(fill_level), 32'h0);
    check("bp_valid0", 32'(out_valid), 32'h0);
    check("bp_ovf_sticky", 32'(overflow), 32'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("bp_ovf_clr", 32'(overflow), 32'h0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    send_word(8'h01, 1'b0, 1'b0);
    send_word(8'h02, 1'b0, 1'b0);
    send_word(8'h03, 1'b0, 1'b0);
    send_word(8'h04, 1'b0, 1'b0);
    check("pp_fill4", 32'(fill_level), 32'h4);
    send_word(8'h66, 1'b0, 1'b1);
    check("pp_fill_keep", 32'(fill_level), 32'h4);
    check("pp_ovf0", 32'(overflow), 32'h0);
    check("pp_d1", 32'(out_data), 32'h02); tick();
    check("pp_d2", 32'(out_data), 32'h03); tick();
    check("pp_d3", 32'(out_data), 32'h04); tick();
    check("pp_d4", 32'(out_data), 32'h66); tick();
    check("pp_empty", 32'(fill_level), 32'h0);

    // Align restart, including align on the would-be last bit
    out_ready = 1'b0;
    send_bits(8'hE0, 3);
    align = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    tick();
    align = 1'b0;
    send_bits(8'h78, 7);
    check("al_fill", 32'(fill_level), 32'h1);
    check("al_data", 32'(out_data), 32'h3C);
    send_bits(8'hFE, 7);
    align = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    align = 1'b0; in_valid = 1'b0;
    check("al_last_nopush", 32'(fill_level), 32'h1);
    send_bits(8'h02, 7);
    check("al_fill2", 32'(fill_level), 32'h2);
    out_ready = 1'b1;
    check("al_d0", 32'(out_data), 32'h3C); tick();
    check("al_d1", 32'(out_data), 32'h81); tick();
    check("al_empty", 32'(fill_level), 32'h0);

    // Reset mid-operation
    out_ready = 1'b0;
    send_word(8'h12, 1'b0, 1'b0);
    send_word(8'h34, 1'b0, 1'b0);
    send_bits(8'hFF, 5);
    check("mr_fill2", 32'(fill_level), 32'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_fill", 32'(fill_level), 32'h0);
    check("mr_ovf", 32'(overflow), 32'h0);
    check("mr_data", 32'(out_data), 32'h0);
    send_word(8'h5A, 1'b0, 1'b0);
    check("mr_clean_fill", 32'(fill_level), 32'h1);
    check("mr_clean_data", 32'(out_data), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/audio_bit_deserializer.md
Name: audio_bit_deserializer

Overview:
- Downstream consumer of the 1-bit-per-clock audio memory reader.
- Packs the serial bit stream, MSB-first, into SAMPLE_W-bit PCM words.
- Buffers completed words in a small FIFO and presents them on a valid/ready interface to the next processing stage (filter/PWM).
- Provides alignment restart, overflow detection and a fill-level indicator.

Parameters:
- SAMPLE_W, 8, bits per assembled sample (≥2).
- ADDR_W, 2, FIFO address width; depth = 2**ADDR_W (default 4 words).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_bit  input  1  serial audio bit from the memory reader.
- in_valid  input  1  in_bit is valid this cycle.
- align  input  1  discard partial word; next accepted bit is the MSB of a new word.
- out_data  output  SAMPLE_W  FIFO head sample.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- fill_level  output  ADDR_W+1  words currently stored, 0..2**ADDR_W.
- overflow  output  1  sticky: a completed word was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. When reset is high at a rising edge, clear the shift register, bit counter, FIFO pointers and overflow. After that edge: out_data=0, out_valid=0, fill_level=0, overflow=0. Reset mid-word discards the partial word. Reset mid-drain discards all stored words.
- Assembly: shift register sh and bit counter bc in 0..SAMPLE_W-1.
  - in_valid=1, align=0: sh <= {sh[SAMPLE_W-2:0], in_bit}; bc <= bc+1.
  - When bc==SAMPLE_W-1, the completed word {sh[SAMPLE_W-2:0], in_bit} is a push request on that edge, and bc wraps to 0.
- in_valid=0: sh and bc hold. Gaps of any length are legal.
- align=1: bc <= 0 and the partial word is discarded. No push occurs, even when bc==SAMPLE_W-1.
  - If in_valid=1 in the same cycle, in_bit becomes the MSB of the new word and bc <= 1.
  - align has priority over completion.
- FIFO:
  - Pop when out_valid && out_ready.
  - Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle. Simultaneous push and pop leave fill_level unchanged.
  - A push request while full with no pop drops the new word (stored words are untouched) and sets overflow=1.
  - Pop while empty is ignored.
  - Pointers wrap modulo 2**ADDR_W. fill_level uses ADDR_W+1 bits to distinguish full from empty.
- Latency:
  - out_valid rises in the cycle after the edge that captured the last bit of a word, when the FIFO was empty.
  - out_data is the registered FIFO head and changes only after a pop edge, a push-into-empty edge, or reset.
- Ordering: words leave in arrival order. No reordering and no duplication.
- overflow: sticky until clr_ovf=1 or reset. If clr_ovf=1 and a new drop occur in the same cycle, overflow stays 1 (set wins).
- Arithmetic: unsigned bit counter and pointers. No sign handling; samples pass through bit-exact.

Test Plan:
- Basic pack: out_ready=1; feed bits 1,0,1,0,0,1,0,1 on consecutive cycles with in_valid=1 -> out_data=0xA5 and out_valid=1 one cycle after the 8th bit; pops next cycle, fill_level returns to 0.
- Gapped input: same 0xA5 bits with in_valid toggling 1,0,1,0,... -> identical 0xA5, no extra words.
- Backpressure: out_ready=0; feed words 0x11,0x22,0x33,0x44,0x55 -> fill_level=4, overflow=1, 0x55 lost. Then out_ready=1 -> drain order 0x11,0x22,0x33,0x44, fill_level=0, overflow still 1. Then clr_ovf=1 -> overflow=0.
- Full push+pop: fill_level=4, out_ready=1, and last bit of 0x66 arrives -> no drop, fill_level stays 4, overflow stays 0, 0x66 emerges fifth.
- Align: feed 3 bits 1,1,1, then align=1 with in_valid=1 and in_bit=0, then bits 0,1,1,1,1,0,0 -> single word 0x3C, partial bits discarded.
- Reset mid-operation: two words stored plus 5 bits of a third, reset=1 for one cycle -> out_valid=0, fill_level=0, overflow=0. Next 8 bits form a clean word.
